// File: rtl/simple_hier_acc.sv
// simple_hier_acc: buffers upstream samples in a small FIFO and folds them into
// windows of WIN samples (saturating sum, bitwise OR, count, saturation flag).
// Latency: pop >= 1 cycle after push; result valid the cycle after the closing pop/flush.
// Backpressure: in_ready drops only when the FIFO is full; EMIT holds the result until out_ready.

// simple_hier_acc_fifo: circular buffer with registered occupancy, DEPTH a power of two.
// Latency: a word written in cycle t is readable from cycle t+1.
// Backpressure: wr_rdy = !full from registered occupancy only, so it never depends on a same-cycle read.
module simple_hier_acc_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             wr_rdy,
  input  logic             rd_en,
  output logic             rd_vld,
  output logic [WIDTH-1:0] rd_dat
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      occ_q, occ_d;
  logic             do_wr, do_rd;

  assign wr_rdy = (occ_q != OCC_FULL);
  assign rd_vld = (occ_q != '0);
  assign rd_dat = mem[rd_ptr_q];
  assign do_wr  = wr_vld && wr_rdy;
  assign do_rd  = rd_en && rd_vld;

  // Pointers wrap naturally modulo DEPTH; occupancy spans 0..DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_wr, do_rd})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the buffer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage array; contents are don't-care while the slot is not occupied.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= wr_dat;
  end
endmodule

// simple_hier_acc: window accumulator behind the input FIFO, two-state ACCUM/EMIT FSM.
// Latency: one pop per cycle in ACCUM; out_valid the cycle after the closing pop or flush.
// Backpressure: EMIT stops popping until out_ready; upstream stalls only once the FIFO fills.
module simple_hier_acc #(
  parameter int WIDTH = 16,
  parameter int WIN   = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [WIDTH-1:0] out_or,
  output logic [7:0]       out_cnt,
  output logic             out_sat
);
  typedef enum logic {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } state_e;

  localparam logic [7:0] WIN_CNT = 8'(WIN);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sum_acc_q, sum_acc_d;
  logic [WIDTH-1:0] or_acc_q, or_acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             sat_acc_q, sat_acc_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic [WIDTH-1:0] out_or_q, out_or_d;
  logic [7:0]       out_cnt_q, out_cnt_d;
  logic             out_sat_q, out_sat_d;

  logic             fifo_rd_vld;
  logic [WIDTH-1:0] fifo_rd_dat;
  logic             pop;
  logic             load_out;
  logic             clr_acc;

  logic [WIDTH:0]   sum_wide;
  logic             ovf;
  logic [WIDTH-1:0] sum_upd, or_upd;
  logic [7:0]       cnt_upd;
  logic             sat_upd;
  logic [WIDTH-1:0] sum_aft, or_aft;
  logic [7:0]       cnt_aft;
  logic             sat_aft;
  logic             win_full, flush_close;

  simple_hier_acc_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_vld  (in_valid),
    .wr_dat  (in_data),
    .wr_rdy  (in_ready),
    .rd_en   (pop),
    .rd_vld  (fifo_rd_vld),
    .rd_dat  (fifo_rd_dat)
  );

  // Candidate accumulator values if the FIFO head is folded in this cycle.
  always_comb begin
    sum_wide = {1'b0, sum_acc_q} + {1'b0, fifo_rd_dat};
    ovf      = sum_wide[WIDTH];
    sum_upd  = ovf ? {WIDTH{1'b1}} : sum_wide[WIDTH-1:0];
    or_upd   = or_acc_q | fifo_rd_dat;
    cnt_upd  = cnt_q + 8'd1;
    sat_upd  = sat_acc_q | ovf;
    sum_aft  = pop ? sum_upd : sum_acc_q;
    or_aft   = pop ? or_upd  : or_acc_q;
    cnt_aft  = pop ? cnt_upd : cnt_q;
    sat_aft  = pop ? sat_upd : sat_acc_q;
    // A flush closes the window only if it holds something after this cycle's pop.
    win_full    = pop && (cnt_upd == WIN_CNT);
    flush_close = flush && (cnt_aft != 8'd0);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ACCUM;
    else          state_q <= state_d;
  end

  // FSM next state: close on full window or effective flush, reopen on result handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (win_full || flush_close) state_d = EMIT;
      EMIT:    if (out_ready)               state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // FSM outputs: pop only while accumulating, present the result while emitting.
  always_comb begin
    pop       = 1'b0;
    load_out  = 1'b0;
    clr_acc   = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ACCUM: begin
        pop      = fifo_rd_vld;
        load_out = win_full || flush_close;
      end
      EMIT: begin
        out_valid = 1'b1;
        clr_acc   = out_ready;
      end
      default: ;
    endcase
  end

  // Accumulator next values: clear after the result is taken, else fold in the popped sample.
  always_comb begin
    sum_acc_d = sum_acc_q;
    or_acc_d  = or_acc_q;
    cnt_d     = cnt_q;
    sat_acc_d = sat_acc_q;
    if (clr_acc) begin
      sum_acc_d = '0;
      or_acc_d  = '0;
      cnt_d     = '0;
      sat_acc_d = 1'b0;
    end else if (pop) begin
      sum_acc_d = sum_upd;
      or_acc_d  = or_upd;
      cnt_d     = cnt_upd;
      sat_acc_d = sat_upd;
    end
  end

  // Accumulator registers; reset drops any partial window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_acc_q <= '0;
      or_acc_q  <= '0;
      cnt_q     <= '0;
      sat_acc_q <= 1'b0;
    end else begin
      sum_acc_q <= sum_acc_d;
      or_acc_q  <= or_acc_d;
      cnt_q     <= cnt_d;
      sat_acc_q <= sat_acc_d;
    end
  end

  // Result next values: capture the post-pop accumulators when the window closes.
  always_comb begin
    out_sum_d = out_sum_q;
    out_or_d  = out_or_q;
    out_cnt_d = out_cnt_q;
    out_sat_d = out_sat_q;
    if (load_out) begin
      out_sum_d = sum_aft;
      out_or_d  = or_aft;
      out_cnt_d = cnt_aft;
      out_sat_d = sat_aft;
    end
  end

  // Result registers; held stable through EMIT, zeroed asynchronously by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_sum_q <= '0;
      out_or_q  <= '0;
      out_cnt_q <= '0;
      out_sat_q <= 1'b0;
    end else begin
      out_sum_q <= out_sum_d;
      out_or_q  <= out_or_d;
      out_cnt_q <= out_cnt_d;
      out_sat_q <= out_sat_d;
    end
  end

  assign out_sum = out_sum_q;
  assign out_or  = out_or_q;
  assign out_cnt = out_cnt_q;
  assign out_sat = out_sat_q;
endmodule

// File: tb/tb_simple_hier_acc.sv
// tb_simple_hier_acc: directed scenarios plus randomized traffic checked against a
// window-level reference model (queue of accepted samples, plain integer arithmetic).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_simple_hier_acc;
  localparam int    W    = 16;
  localparam int    WN   = 4;
  localparam int    D    = 4;
  localparam longint MAXV = (longint'(1) << W) - 1;

  logic         clk       = 1'b0;
  logic         reset_n   = 1'b0;
  logic         in_valid  = 1'b0;
  logic [W-1:0] in_data   = '0;
  logic         flush     = 1'b0;
  logic         out_ready = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_sum;
  logic [W-1:0] out_or;
  logic [7:0]   out_cnt;
  logic         out_sat;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en   = 1'b0;

  logic [W-1:0] exp_q [$];
  int           mk;
  longint       tot;
  logic [W-1:0] mor;

  always #5 clk = ~clk;

  simple_hier_acc #(
    .WIDTH (W),
    .WIN   (WN),
    .DEPTH (D)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_or    (out_or),
    .out_cnt   (out_cnt),
    .out_sat   (out_sat)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_val("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_vld();
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_out(input string tag, input logic [W-1:0] s, input logic [W-1:0] o,
                          input logic [7:0] c, input logic sat);
    wait_vld();
    check_val({tag, "_vld"}, 32'(out_valid), 32'd1);
    check_val({tag, "_sum"}, 32'(out_sum), 32'(s));
    check_val({tag, "_or"},  32'(out_or),  32'(o));
    check_val({tag, "_cnt"}, 32'(out_cnt), 32'(c));
    check_val({tag, "_sat"}, 32'(out_sat), 32'(sat));
    tick();
  endtask

  // Reference model: each result covers the oldest WN accepted samples, or the
  // remaining partial window when fewer are outstanding (final flush).
  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check_val("mon_spurious", 32'(out_valid), 32'd0);
        end else begin
          mk  = (exp_q.size() < WN) ? exp_q.size() : WN;
          tot = 0;
          mor = '0;
          for (int i = 0; i < mk; i++) begin
            tot += longint'(exp_q[i]);
            mor |= exp_q[i];
          end
          check_val("mon_sum", 32'(out_sum), (tot > MAXV) ? 32'(MAXV) : 32'(tot));
          check_val("mon_or",  32'(out_or),  32'(mor));
          check_val("mon_cnt", 32'(out_cnt), 32'(mk));
          check_val("mon_sat", 32'(out_sat), (tot > MAXV) ? 32'd1 : 32'd0);
          if (out_ready) begin
            for (int i = 0; i < mk; i++) void'(exp_q.pop_front());
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(in_data);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) tick();
    check_val("rst_vld", 32'(out_valid), 32'd0);
    check_val("rst_sum", 32'(out_sum), 32'd0);
    check_val("rst_cnt", 32'(out_cnt), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check_val("rel_in_ready", 32'(in_ready), 32'd1);
    check_val("rel_out_vld", 32'(out_valid), 32'd0);
    tick();

    // Basic window
    out_ready = 1'b1;
    send(16'd1); send(16'd2); send(16'd3); send(16'd4);
    wait_out("basic", 16'h000A, 16'h0007, 8'd4, 1'b0);
    @(negedge clk);
    check_val("basic_vld_drop", 32'(out_valid), 32'd0);
    tick();

    // Saturation
    send(16'hFFFF); send(16'h0002); send(16'h0000); send(16'h0000);
    wait_out("sat", 16'hFFFF, 16'hFFFF, 8'd4, 1'b1);

    // Backpressure: first result held while the FIFO fills behind it
    out_ready = 1'b0;
    repeat (8) send(16'h0001);
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("bp_hold_vld", 32'(out_valid), 32'd1);
      check_val("bp_hold_sum", 32'(out_sum), 32'd4);
      check_val("bp_full", 32'(in_ready), 32'd0);
      flush = (i == 1);
    end
    tick();
    flush = 1'b0;
    out_ready = 1'b1;
    wait_out("bp1", 16'd4, 16'd1, 8'd4, 1'b0);
    wait_out("bp2", 16'd4, 16'd1, 8'd4, 1'b0);
    @(negedge clk);
    check_val("bp_ready_back", 32'(in_ready), 32'd1);
    tick();

    // Flush of a partial window
    send(16'd3); send(16'd3); send(16'd3);
    tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_out("flush3", 16'd9, 16'd3, 8'd3, 1'b0);
    // Flush with an empty window must not produce a result
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_val("flush_empty", 32'(out_valid), 32'd0);
    end
    tick();
    // Flush coinciding with the pop of the only sample includes that sample
    send(16'd7);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_out("flush_pop", 16'd7, 16'd7, 8'd1, 1'b0);

    // Asynchronous reset while a result is being held
    out_ready = 1'b0;
    send(16'hF000); send(16'h2000); send(16'h0000); send(16'h0000);
    wait_vld();
    check_val("pre_rst_sum", 32'(out_sum), 32'hFFFF);
    check_val("pre_rst_sat", 32'(out_sat), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("arst_vld", 32'(out_valid), 32'd0);
    check_val("arst_sum", 32'(out_sum), 32'd0);
    check_val("arst_or",  32'(out_or),  32'd0);
    check_val("arst_cnt", 32'(out_cnt), 32'd0);
    check_val("arst_sat", 32'(out_sat), 32'd0);
    tick(); tick();
    reset_n   = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check_val("arst_rel_ready", 32'(in_ready), 32'd1);
    check_val("arst_rel_vld", 32'(out_valid), 32'd0);
    tick();

    // Reset mid-window discards the partial data
    send(16'd9); send(16'd9);
    #3;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    send(16'd5); send(16'd5); send(16'd5); send(16'd5);
    wait_out("rst_win", 16'h0014, 16'h0005, 8'd4, 1'b0);
    repeat (3) tick();

    // Randomized traffic against the window-level model
    mon_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = ($urandom_range(0, 7) == 0) ? W'($urandom) : W'($urandom_range(0, 255));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (40) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (10) tick();
    check_val("drain_empty", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/simple_hier_acc.md
SIMPLE_HIER_ACC -- requirements
Module: simple_hier_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data width of each incoming sample.
REQ-002 SHALL have parameter WIN, default 4: samples per accumulation window, legal range 2..255.
REQ-003 SHALL have parameter DEPTH, default 4: input FIFO entries, power of two, at least 2.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1: in_data holds a sample.
REQ-007 SHALL have port in_ready, output, 1: block accepts a sample this cycle.
REQ-008 SHALL have port in_data, input, WIDTH: sample, i.e. the upstream hierarchy's output word.
REQ-009 SHALL have port flush, input, 1: single-cycle request to emit a partial window.
REQ-010 SHALL have port out_valid, output, 1: window result present.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-012 SHALL have port out_sum, output, WIDTH: saturating sum of the window's samples.
REQ-013 SHALL have port out_or, output, WIDTH: bitwise OR of the window's samples.
REQ-014 SHALL have port out_cnt, output, 8: number of samples in the window.
REQ-015 SHALL have port out_sat, output, 1: saturation occurred in the window.

Function
REQ-016 SHALL push in_data into the FIFO when in_valid && in_ready.
REQ-017 SHALL drive in_ready = !full, derived from registered occupancy only and independent of in_valid and of a same-cycle pop.
REQ-018 SHALL have exactly two FSM states, ACCUM and EMIT.
REQ-019 In ACCUM with FIFO non-empty, SHALL pop one sample per cycle and update state as follows: sum_acc = min(sum_acc + data, 2^WIDTH-1); or_acc |= data; cnt++; sat_acc |= overflow.
REQ-020 SHALL transition ACCUM->EMIT on the pop that makes cnt == WIN, loading out_* from the updated accumulators.
REQ-021 SHALL transition ACCUM->EMIT on a flush cycle when the cnt value after any same-cycle pop is >0; a sample popped in the flush cycle is included.
REQ-022 SHALL ignore flush when cnt == 0 with no same-cycle pop, and SHALL ignore flush in EMIT.
REQ-023 In EMIT, SHALL hold out_valid=1 and keep out_* stable until out_ready; SHALL perform no pops in EMIT while FIFO pushes continue.
REQ-024 On the EMIT handshake, SHALL clear the accumulators and cnt, return to ACCUM, and set out_valid=0 on the next cycle.
REQ-025 Latency: a sample pushed in cycle t SHALL be popped no earlier than t+1; out_valid SHALL rise the cycle after the closing pop or flush.
REQ-026 Throughput: with out_ready=1 and continuous input, SHALL sustain WIN samples per WIN+1 cycles.
REQ-027 SHALL keep FIFO read and write pointers wrapping modulo DEPTH, with occupancy tracked 0..DEPTH.

Reset
REQ-028 While reset_n=0, SHALL asynchronously drive out_valid=0, out_sum=0, out_or=0, out_cnt=0, out_sat=0.
REQ-029 While reset_n=0, SHALL clear the FIFO to empty, set in_ready=1 when released, set state=ACCUM, and clear all accumulators.
REQ-030 Reset mid-window or mid-EMIT SHALL discard all buffered and partial data.

Verification
REQ-031 Reset: assert reset_n=0 asynchronously mid-cycle -> outputs immediately 0; after release in_ready=1, out_valid=0.
REQ-032 Basic window: push 1,2,3,4 back-to-back with out_ready=1 -> one result: out_sum=0x000A, out_or=0x0007, out_cnt=4, out_sat=0.
REQ-033 Saturation: push 0xFFFF,0x0002,0x0000,0x0000 -> out_sum=0xFFFF, out_or=0xFFFF, out_sat=1.
REQ-034 Backpressure: out_ready=0, push 8 samples of 0x0001 -> first result held stable (sum 4); FIFO fills and in_ready=0 with 4 queued; after out_ready=1 -> second result sum 4 and in_ready returns to 1.
REQ-035 Flush: push 3,3,3 then pulse flush -> out_sum=9, out_cnt=3; flush with empty window -> no out_valid.
REQ-036 Reset mid-window: push 2 samples, pulse reset_n low, then push 5,5,5,5 -> out_sum=0x0014, out_cnt=4.
